// File: rtl/vsdserializer_pkg.sv
// Shared types and helpers for the vsdserializer_v2 parallel-to-serial converter.
package vsdserializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter width that stays at least one bit wide even for n == 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vsd_bit_tick.sv
// Bit-period divider: counts DIV cycles per serial bit and flags the last and first cycle.
module vsd_bit_tick
  import vsdserializer_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  input  logic run_i,
  output logic tick_o,
  output logic tick_next_o,
  output logic first_next_o
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !run_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Next-cycle flags let the parent register its framing strobes.
  assign tick_o       = (cnt_q == LAST);
  assign tick_next_o  = (cnt_d == LAST);
  assign first_next_o = (cnt_d == '0);

endmodule

// File: rtl/vsdserializer_v2.sv
// Parallel-to-serial converter with valid/ready intake, one-word holding buffer,
// bit-period divider, selectable bit order, abort and framing strobes.
module vsdserializer_v2
  import vsdserializer_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter bit LSB_FIRST  = 1'b0,
  parameter int DIV        = 1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             accept;
  logic             load;
  logic             tick;
  logic             tick_next;
  logic             first_next;

  assign in_ready = !buf_full_q && !abort && rst_n;
  assign accept   = in_valid && in_ready;

  vsd_bit_tick #(
    .DIV (DIV)
  ) u_bit_tick (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart_i    (load || abort),
    .run_i        (state_q == SHIFT),
    .tick_o       (tick),
    .tick_next_o  (tick_next),
    .first_next_o (first_next)
  );

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    bit_cnt_d  = bit_cnt_q;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          shift_d   = in_data;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            // The buffered word wins; in_ready is low whenever it is present.
            if (buf_full_q) begin
              load       = 1'b1;
              shift_d    = buf_q;
              buf_full_d = 1'b0;
            end else if (accept) begin
              load    = 1'b1;
              shift_d = in_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
          end
        end
        if (accept && !load) begin
          buf_d      = in_data;
          buf_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d    = IDLE;
      shift_d    = '0;
      buf_d      = '0;
      buf_full_d = 1'b0;
      bit_cnt_d  = '0;
      load       = 1'b0;
    end
  end

  // Outputs are registered from next-state values so they line up with the shifter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      bit_cnt_q   <= '0;
      ser_out     <= IDLE_LEVEL;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_out     <= (state_d == SHIFT) ? head_bit(shift_d) : IDLE_LEVEL;
      ser_valid   <= (state_d == SHIFT);
      frame_start <= (state_d == SHIFT) && (bit_cnt_d == '0) && first_next;
      frame_last  <= (state_d == SHIFT) && (bit_cnt_d == LAST_BIT) && tick_next;
      busy        <= (state_d == SHIFT) || buf_full_d;
    end
  end

endmodule

// File: tb/tb_vsdserializer_v2.sv
// Self-checking bench for vsdserializer_v2: three configurations checked against a bit-stream scoreboard.
module tb_vsdserializer_v2;

  typedef struct packed {
    logic so;
    logic sv;
    logic fs;
    logic fl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] in_data;
  logic       abort;
  logic       valid_m, valid_l, valid_d;
  logic       ready_m, ready_l, ready_d;
  logic       so_m, sv_m, fs_m, fl_m, bz_m;
  logic       so_l, sv_l, fs_l, fl_l, bz_l;
  logic       so_d, sv_d, fs_d, fl_d, bz_d;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  vsdserializer_v2 #(.WIDTH(10), .LSB_FIRST(1'b0), .DIV(1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_m), .in_ready(ready_m), .in_data(in_data),
    .abort(abort), .ser_out(so_m), .ser_valid(sv_m), .frame_start(fs_m),
    .frame_last(fl_m), .busy(bz_m)
  );

  vsdserializer_v2 #(.WIDTH(10), .LSB_FIRST(1'b1), .DIV(1), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_l), .in_ready(ready_l), .in_data(in_data),
    .abort(1'b0), .ser_out(so_l), .ser_valid(sv_l), .frame_start(fs_l),
    .frame_last(fl_l), .busy(bz_l)
  );

  vsdserializer_v2 #(.WIDTH(10), .LSB_FIRST(1'b0), .DIV(3), .IDLE_LEVEL(1'b0)) u_div (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_d), .in_ready(ready_d), .in_data(in_data),
    .abort(1'b0), .ser_out(so_d), .ser_valid(sv_d), .frame_start(fs_d),
    .frame_last(fl_d), .busy(bz_d)
  );

  // Expected per-cycle stream of one frame: bit order, hold length and framing strobes.
  function automatic void push_frame(input logic [9:0] w, input bit lsb, input int div);
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < div; d++) begin
        e.so = lsb ? w[i] : w[9-i];
        e.sv = 1'b1;
        e.fs = (i == 0) && (d == 0);
        e.fl = (i == 9) && (d == div - 1);
        sb.push_back(e);
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; abort = 1'b0; in_data = 10'h3FF;
    valid_m = 1'b1; valid_l = 1'b0; valid_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready_m !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready_m); end
    checks++;
    if ({so_m, sv_m, fs_m, fl_m, bz_m} !== 5'b00000) begin
      errors++; $display("FAIL reset_msb_outs got %b exp 00000", {so_m, sv_m, fs_m, fl_m, bz_m});
    end
    checks++;
    if ({so_l, sv_l, fs_l, fl_l, bz_l} !== 5'b10000) begin
      errors++; $display("FAIL reset_lsb_outs got %b exp 10000", {so_l, sv_l, fs_l, fl_l, bz_l});
    end
    checks++;
    if ({so_d, sv_d, fs_d, fl_d, bz_d} !== 5'b00000) begin
      errors++; $display("FAIL reset_div_outs got %b exp 00000", {so_d, sv_d, fs_d, fl_d, bz_d});
    end
    valid_m = 1'b0; rst_n = 1'b1;
    #1;
    checks++;
    if (ready_m !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", ready_m); end
    $display("reset: done");
  endtask

  task automatic test_basic();
    exp_t e;
    @(posedge clk); #1;
    in_data = 10'h2A5; valid_m = 1'b1;
    #1;
    checks++;
    if (ready_m !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", ready_m); end
    @(posedge clk); #1;
    valid_m = 1'b0;
    push_frame(10'h2A5, 1'b0, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({so_m, sv_m, fs_m, fl_m} !== e || bz_m !== 1'b1) begin
        errors++; $display("FAIL basic_bit got so,sv,fs,fl,busy=%b%b exp %b1", {so_m, sv_m, fs_m, fl_m}, bz_m, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({so_m, sv_m, fs_m, fl_m, bz_m} !== 5'b00000) begin
      errors++; $display("FAIL basic_idle got %b exp 00000", {so_m, sv_m, fs_m, fl_m, bz_m});
    end
    $display("basic: word 2A5 msb-first sent");
  endtask

  task automatic test_lsb_first();
    exp_t e;
    @(posedge clk); #1;
    in_data = 10'h2A5; valid_l = 1'b1;
    @(posedge clk); #1;
    valid_l = 1'b0;
    push_frame(10'h2A5, 1'b1, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({so_l, sv_l, fs_l, fl_l} !== e || bz_l !== 1'b1) begin
        errors++; $display("FAIL lsb_bit got so,sv,fs,fl,busy=%b%b exp %b1", {so_l, sv_l, fs_l, fl_l}, bz_l, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({so_l, sv_l, fs_l, fl_l, bz_l} !== 5'b10000) begin
      errors++; $display("FAIL lsb_idle got %b exp 10000", {so_l, sv_l, fs_l, fl_l, bz_l});
    end
    $display("lsb_first: word 2A5 lsb-first sent");
  endtask

  task automatic test_divider();
    exp_t e;
    @(posedge clk); #1;
    in_data = 10'h2A5; valid_d = 1'b1;
    @(posedge clk); #1;
    valid_d = 1'b0;
    push_frame(10'h2A5, 1'b0, 3);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({so_d, sv_d, fs_d, fl_d} !== e) begin
        errors++; $display("FAIL div_bit got so,sv,fs,fl=%b exp %b", {so_d, sv_d, fs_d, fl_d}, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({so_d, sv_d, fs_d, fl_d, bz_d} !== 5'b00000) begin
      errors++; $display("FAIL div_idle got %b exp 00000", {so_d, sv_d, fs_d, fl_d, bz_d});
    end
    $display("divider: 30-cycle frame sent");
  endtask

  task automatic test_back_to_back();
    logic [9:0] words [3];
    exp_t e;
    int   idx;
    bit   exp_rdy;
    bit   acc;
    words[0] = 10'h3FF; words[1] = 10'h000; words[2] = 10'h155;
    idx = 0;
    @(posedge clk); #1;
    in_data = words[0]; valid_m = 1'b1;
    for (int k = 0; k < 34; k++) begin
      #1;
      exp_rdy = (k <= 1) || (k == 11) || (k >= 21);
      checks++;
      if (ready_m !== exp_rdy) begin
        errors++; $display("FAIL b2b_ready cycle %0d got %b exp %b", k, ready_m, exp_rdy);
      end
      acc = valid_m && exp_rdy;
      @(posedge clk); #1;
      if (acc) begin
        push_frame(words[idx], 1'b0, 1);
        idx++;
        if (idx < 3) in_data = words[idx];
        else valid_m = 1'b0;
      end
      checks++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if ({so_m, sv_m, fs_m, fl_m} !== e || bz_m !== 1'b1) begin
          errors++; $display("FAIL b2b_bit cycle %0d got so,sv,fs,fl,busy=%b%b exp %b1", k, {so_m, sv_m, fs_m, fl_m}, bz_m, e);
        end
      end else if ({so_m, sv_m, fs_m, fl_m, bz_m} !== 5'b00000) begin
        errors++; $display("FAIL b2b_idle cycle %0d got %b exp 00000", k, {so_m, sv_m, fs_m, fl_m, bz_m});
      end
    end
    $display("back_to_back: 3FF 000 155 sent, %0d words accepted", idx);
  endtask

  task automatic test_abort();
    exp_t e;
    bit   seen;
    @(posedge clk); #1;
    in_data = 10'h2A5; valid_m = 1'b1;
    @(posedge clk); #1;
    push_frame(10'h2A5, 1'b0, 1);
    in_data = 10'h3C3;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 1) begin push_frame(10'h3C3, 1'b0, 1); valid_m = 1'b0; end
      e = sb.pop_front();
      checks++;
      if ({so_m, sv_m, fs_m, fl_m} !== e) begin
        errors++; $display("FAIL abort_pre bit %0d got %b exp %b", c, {so_m, sv_m, fs_m, fl_m}, e);
      end
    end
    abort = 1'b1;
    #1;
    checks++;
    if (ready_m !== 1'b0 || bz_m !== 1'b1) begin
      errors++; $display("FAIL abort_ready got ready=%b busy=%b exp ready=0 busy=1", ready_m, bz_m);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    sb.delete();
    checks++;
    if ({so_m, sv_m, fs_m, fl_m, bz_m} !== 5'b00000) begin
      errors++; $display("FAIL abort_flush got %b exp 00000", {so_m, sv_m, fs_m, fl_m, bz_m});
    end
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (sv_m !== 1'b0 || fl_m !== 1'b0 || bz_m !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_buffer_dropped got activity=1 exp 0"); end
    in_data = 10'h0F0; valid_m = 1'b1;
    @(posedge clk); #1;
    valid_m = 1'b0;
    push_frame(10'h0F0, 1'b0, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({so_m, sv_m, fs_m, fl_m} !== e) begin
        errors++; $display("FAIL abort_restart got %b exp %b", {so_m, sv_m, fs_m, fl_m}, e);
      end
      @(posedge clk); #1;
    end
    $display("abort: frame flushed, word 0F0 sent cleanly");
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(posedge clk); #1;
    in_data = 10'h155; valid_m = 1'b1;
    @(posedge clk); #1;
    valid_m = 1'b0;
    push_frame(10'h155, 1'b0, 1);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      e = sb.pop_front();
      checks++;
      if ({so_m, sv_m, fs_m, fl_m} !== e) begin
        errors++; $display("FAIL rstmid_pre bit %0d got %b exp %b", c, {so_m, sv_m, fs_m, fl_m}, e);
      end
    end
    rst_n = 1'b0; in_data = 10'h001; valid_m = 1'b1;
    #1;
    checks++;
    if (ready_m !== 1'b0) begin errors++; $display("FAIL rstmid_ready_low got %b exp 0", ready_m); end
    @(posedge clk); #1;
    checks++;
    if ({so_m, sv_m, fs_m, fl_m, bz_m} !== 5'b00000) begin
      errors++; $display("FAIL rstmid_outs got %b exp 00000", {so_m, sv_m, fs_m, fl_m, bz_m});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (ready_m !== 1'b1) begin errors++; $display("FAIL rstmid_ready_high got %b exp 1", ready_m); end
    @(posedge clk); #1;
    valid_m = 1'b0;
    push_frame(10'h001, 1'b0, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({so_m, sv_m, fs_m, fl_m} !== e) begin
        errors++; $display("FAIL rstmid_after got %b exp %b", {so_m, sv_m, fs_m, fl_m}, e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({so_m, sv_m, fs_m, fl_m, bz_m} !== 5'b00000) begin
      errors++; $display("FAIL rstmid_idle got %b exp 00000", {so_m, sv_m, fs_m, fl_m, bz_m});
    end
    $display("reset_mid: frame truncated, word 001 sent");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lsb_first();
    test_divider();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
